// File: rtl/ter_addr_seq_pkg.sv
// Shared constants for the TER interleaver RAM sequencer: link-length table and FSM state types.
package ter_pkg;

    localparam int unsigned LEN_W  = 13;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned N_LINK = 9;

    // Supported block lengths and their base offsets in the interleaver RAM
    localparam logic [LEN_W-1:0] LINK_LEN [N_LINK] = '{
        13'h01B0, 13'h03CC, 13'h0510, 13'h0380, 13'h07E0,
        13'h0A80, 13'h0750, 13'h0FC0, 13'h15F0
    };
    localparam logic [ADDR_W-1:0] LINK_OFS [N_LINK] = '{
        16'h0000, 16'h01B6, 16'h0588, 16'h0A9E, 16'h0E24,
        16'h160A, 16'h2090, 16'h27E6, 16'h37AC
    };

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ter_len_lut.sv
// Combinational block-length to RAM base-offset lookup; o_hit_c low for unsupported lengths.
module ter_len_lut #(
    parameter int unsigned LEN_W  = ter_pkg::LEN_W,
    parameter int unsigned ADDR_W = ter_pkg::ADDR_W,
    parameter int unsigned N_LINK = ter_pkg::N_LINK
) (
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_hit_c,
    output logic [ADDR_W-1:0] o_ofs_c
);

    import ter_pkg::*;

    always_comb begin
        o_hit_c = 1'b0;
        o_ofs_c = '0;
        for (int i = 0; i < N_LINK; i++) begin
            if (i_len == LEN_W'(LINK_LEN[i])) begin
                o_hit_c = 1'b1;
                o_ofs_c = ADDR_W'(LINK_OFS[i]);
            end
        end
    end

endmodule

// File: rtl/ter_addr_seq.sv
// TER interleaver RAM address/enable sequencer with ping-pong banking:
// the write side fills one bank while the read side drains the previous one.
module ter_addr_seq #(
    parameter  int unsigned ADDR_W = ter_pkg::ADDR_W,
    parameter  int unsigned LEN_W  = ter_pkg::LEN_W,
    parameter  int unsigned N_LINK = ter_pkg::N_LINK,
    parameter  int unsigned N_BANK = 2,
    localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              din_vld,
    output logic              din_rdy,
    input  logic [LEN_W-1:0]  m_len,
    input  logic              request,
    output logic              req_rdy,
    output logic              wen,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BANK_W-1:0] wr_bank,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BANK_W-1:0] rd_bank,
    output logic              dout_vld,
    output logic [ADDR_W-1:0] id_offset,
    output logic              len_err,
    output logic              busy
);

    import ter_pkg::*;

    localparam int unsigned CNT_W = LEN_W + 1;

    function automatic logic [BANK_W-1:0] f_next_bank(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(N_BANK - 1)) ? '0 : p + BANK_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] f_last(input logic [LEN_W-1:0] len);
        return CNT_W'(len) - CNT_W'(1);
    endfunction

    wr_state_e         r_wst,     w_wst_nxt;
    rd_state_e         r_rdst,    w_rdst_nxt;
    logic [BANK_W-1:0] r_wr_ptr,  w_wr_ptr_nxt;
    logic [BANK_W-1:0] r_rd_ptr,  w_rd_ptr_nxt;
    logic [N_BANK-1:0] r_full,    w_full_nxt, w_full_set, w_full_clr;
    logic [LEN_W-1:0]  r_len      [N_BANK];
    logic [LEN_W-1:0]  w_len_nxt  [N_BANK];
    logic [ADDR_W-1:0] r_ofs      [N_BANK];
    logic [ADDR_W-1:0] w_ofs_nxt  [N_BANK];
    logic [CNT_W-1:0]  r_wcnt,    w_wcnt_nxt;
    logic [CNT_W-1:0]  r_rcnt,    w_rcnt_nxt;
    logic [CNT_W-1:0]  w_rd_j;

    logic              r_wen,     w_wen_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [BANK_W-1:0] r_wr_bank, w_wr_bank_nxt;
    logic              r_rd_en,   w_rd_en_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [BANK_W-1:0] r_rd_bank, w_rd_bank_nxt;
    logic              r_dout_vld, w_dout_vld_nxt;
    logic              r_len_err, w_len_err_nxt;
    logic              r_din_rdy, w_din_rdy_nxt;
    logic              r_req_rdy, w_req_rdy_nxt;
    logic [ADDR_W-1:0] r_id_ofs,  w_id_ofs_nxt;
    logic              r_busy,    w_busy_nxt;

    logic              w_hit;
    logic [ADDR_W-1:0] w_lut_ofs;

    ter_len_lut #(
        .LEN_W  (LEN_W),
        .ADDR_W (ADDR_W),
        .N_LINK (N_LINK)
    ) u_len_lut (
        .i_len   (m_len),
        .o_hit_c (w_hit),
        .o_ofs_c (w_lut_ofs)
    );

    // Write FSM: m_len is only sampled on the first beat of a block
    always_comb begin
        w_wst_nxt     = r_wst;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_wcnt_nxt    = r_wcnt;
        w_len_nxt     = r_len;
        w_ofs_nxt     = r_ofs;
        w_full_set    = '0;
        w_wen_nxt     = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_bank_nxt = r_wr_bank;
        w_len_err_nxt = 1'b0;
        if (flush) begin
            w_wst_nxt     = W_IDLE;
            w_wr_ptr_nxt  = '0;
            w_wcnt_nxt    = '0;
            w_wr_addr_nxt = '0;
            w_wr_bank_nxt = '0;
        end else begin
            case (r_wst)
                W_IDLE: begin
                    if (din_vld && !w_hit) begin
                        w_len_err_nxt = 1'b1;
                    end else if (din_vld && r_din_rdy) begin
                        w_len_nxt[r_wr_ptr] = m_len;
                        w_ofs_nxt[r_wr_ptr] = w_lut_ofs;
                        w_wen_nxt           = 1'b1;
                        w_wr_addr_nxt       = w_lut_ofs;
                        w_wr_bank_nxt       = r_wr_ptr;
                        if (m_len == LEN_W'(1)) begin
                            w_full_set[r_wr_ptr] = 1'b1;
                            w_wr_ptr_nxt         = f_next_bank(r_wr_ptr);
                        end else begin
                            w_wcnt_nxt = CNT_W'(1);
                            w_wst_nxt  = W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (din_vld) begin
                        w_wen_nxt     = 1'b1;
                        w_wr_addr_nxt = r_ofs[r_wr_ptr] + ADDR_W'(r_wcnt);
                        w_wr_bank_nxt = r_wr_ptr;
                        if (r_wcnt == f_last(r_len[r_wr_ptr])) begin
                            w_full_set[r_wr_ptr] = 1'b1;
                            w_wr_ptr_nxt         = f_next_bank(r_wr_ptr);
                            w_wcnt_nxt           = '0;
                            w_wst_nxt            = W_IDLE;
                        end else begin
                            w_wcnt_nxt = r_wcnt + CNT_W'(1);
                        end
                    end
                end
                default: w_wst_nxt = W_IDLE;
            endcase
        end
    end

    assign w_rd_j = (r_rdst == R_IDLE) ? '0 : r_rcnt;

    // Read FSM: one RAM read per accepted request, bank released on its last beat
    always_comb begin
        w_rdst_nxt    = r_rdst;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_rcnt_nxt    = r_rcnt;
        w_full_clr    = '0;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_bank_nxt = r_rd_bank;
        if (flush) begin
            w_rdst_nxt    = R_IDLE;
            w_rd_ptr_nxt  = '0;
            w_rcnt_nxt    = '0;
            w_rd_addr_nxt = '0;
            w_rd_bank_nxt = '0;
        end else if (request && r_req_rdy) begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = r_ofs[r_rd_ptr] + ADDR_W'(w_rd_j);
            w_rd_bank_nxt = r_rd_ptr;
            if (w_rd_j == f_last(r_len[r_rd_ptr])) begin
                w_full_clr[r_rd_ptr] = 1'b1;
                w_rd_ptr_nxt         = f_next_bank(r_rd_ptr);
                w_rcnt_nxt           = '0;
                w_rdst_nxt           = R_IDLE;
            end else begin
                w_rcnt_nxt = w_rd_j + CNT_W'(1);
                w_rdst_nxt = R_READ;
            end
        end
    end

    // Status outputs are registered from next-state so they line up with the handshakes
    always_comb begin
        w_full_nxt     = flush ? '0 : ((r_full & ~w_full_clr) | w_full_set);
        w_din_rdy_nxt  = !flush && ((w_wst_nxt == W_FILL) || !w_full_nxt[w_wr_ptr_nxt]);
        w_req_rdy_nxt  = w_full_nxt[w_rd_ptr_nxt];
        w_id_ofs_nxt   = w_full_nxt[w_rd_ptr_nxt] ? w_ofs_nxt[w_rd_ptr_nxt] : '0;
        w_busy_nxt     = (|w_full_nxt) || (w_wst_nxt == W_FILL);
        w_dout_vld_nxt = !flush && r_rd_en;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wst      <= W_IDLE;
            r_rdst     <= R_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_full     <= '0;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_wen      <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_bank  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_bank  <= '0;
            r_dout_vld <= 1'b0;
            r_len_err  <= 1'b0;
            r_din_rdy  <= 1'b0;
            r_req_rdy  <= 1'b0;
            r_id_ofs   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_wst      <= w_wst_nxt;
            r_rdst     <= w_rdst_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_full     <= w_full_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_wen      <= w_wen_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_dout_vld <= w_dout_vld_nxt;
            r_len_err  <= w_len_err_nxt;
            r_din_rdy  <= w_din_rdy_nxt;
            r_req_rdy  <= w_req_rdy_nxt;
            r_id_ofs   <= w_id_ofs_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Per-bank block descriptors are only consulted while the bank is owned
    always_ff @(posedge clk) begin
        r_len <= w_len_nxt;
        r_ofs <= w_ofs_nxt;
    end

    assign din_rdy   = r_din_rdy;
    assign req_rdy   = r_req_rdy;
    assign wen       = r_wen;
    assign wr_addr   = r_wr_addr;
    assign wr_bank   = r_wr_bank;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign rd_bank   = r_rd_bank;
    assign dout_vld  = r_dout_vld;
    assign id_offset = r_id_ofs;
    assign len_err   = r_len_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ter_addr_seq.sv
// Directed bench for ter_addr_seq: fill, drain, ping-pong overlap, length error, reset and flush.
module tb_ter_addr_seq;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 13;

    logic              clk     = 1'b0;
    logic              n_rst   = 1'b0;
    logic              flush   = 1'b0;
    logic              din_vld = 1'b0;
    logic              request = 1'b0;
    logic [LEN_W-1:0]  m_len   = '0;
    logic              din_rdy, req_rdy, wen, rd_en, dout_vld, len_err, busy;
    logic [ADDR_W-1:0] wr_addr, rd_addr, id_offset;
    logic [0:0]        wr_bank, rd_bank;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ter_addr_seq dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .m_len     (m_len),
        .request   (request),
        .req_rdy   (req_rdy),
        .wen       (wen),
        .wr_addr   (wr_addr),
        .wr_bank   (wr_bank),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_bank   (rd_bank),
        .dout_vld  (dout_vld),
        .id_offset (id_offset),
        .len_err   (len_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic en, input logic bank, input int addr);
        return {14'd0, en, bank, 16'(addr)};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_flags"}, 32'({din_rdy, req_rdy, wen, wr_bank, rd_en, rd_bank, dout_vld, len_err, busy}), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_id_offset"}, 32'(id_offset), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        cyc(); cyc();
        chk_idle("reset");
        n_rst = 1'b1;
        cyc();
        chk("rst_din_rdy", 32'(din_rdy), 32'd1);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);

        // 0x1B0 block into bank 0
        m_len = 13'h01B0;
        for (int k = 0; k < 432; k++) begin
            din_vld = 1'b1;
            cyc();
            chk("b0_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b0, k));
        end
        din_vld = 1'b0;
        chk("b0_req_rdy", 32'(req_rdy), 32'd1);
        chk("b0_din_rdy", 32'(din_rdy), 32'd1);
        chk("b0_busy", 32'(busy), 32'd1);
        chk("b0_id_offset", 32'(id_offset), 32'h0000);
        cyc();
        chk("b0_wen_off", 32'(wen), 32'd0);

        // 0x3CC block into bank 1
        m_len = 13'h03CC;
        for (int k = 0; k < 972; k++) begin
            din_vld = 1'b1;
            cyc();
            chk("b1_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b1, 32'h01B6 + k));
        end
        din_vld = 1'b0;
        chk("both_full_din_rdy", 32'(din_rdy), 32'd0);
        chk("both_full_req_rdy", 32'(req_rdy), 32'd1);

        // third block stalls while both banks are full
        m_len   = 13'h0510;
        din_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_wen", 32'(wen), 32'd0);
            chk("stall_din_rdy", 32'(din_rdy), 32'd0);
        end
        din_vld = 1'b0;

        // drain bank 0
        for (int j = 0; j < 432; j++) begin
            request = 1'b1;
            cyc();
            chk("rd0", {14'd0, rd_en, rd_bank, rd_addr}, pk(1'b1, 1'b0, j));
            chk("rd0_dout_vld", 32'(dout_vld), (j > 0) ? 32'd1 : 32'd0);
        end
        request = 1'b0;
        chk("rd0_done_req_rdy", 32'(req_rdy), 32'd1);
        chk("rd0_done_id_offset", 32'(id_offset), 32'h01B6);
        chk("rd0_done_din_rdy", 32'(din_rdy), 32'd1);
        cyc();
        chk("rd0_tail_rd_en", 32'(rd_en), 32'd0);
        chk("rd0_tail_dout_vld", 32'(dout_vld), 32'd1);
        cyc();
        chk("rd0_tail2_dout_vld", 32'(dout_vld), 32'd0);

        // drain bank 1
        for (int j = 0; j < 972; j++) begin
            request = 1'b1;
            cyc();
            chk("rd1", {14'd0, rd_en, rd_bank, rd_addr}, pk(1'b1, 1'b1, 32'h01B6 + j));
        end
        request = 1'b0;
        chk("rd1_done_req_rdy", 32'(req_rdy), 32'd0);
        chk("rd1_done_id_offset", 32'(id_offset), 32'h0000);
        chk("rd1_done_busy", 32'(busy), 32'd0);

        // request with nothing to read is ignored
        request = 1'b1;
        cyc();
        chk("norq_rd_en", 32'(rd_en), 32'd0);
        cyc();
        chk("norq_rd_en2", 32'(rd_en), 32'd0);
        chk("norq_dout_vld", 32'(dout_vld), 32'd0);
        request = 1'b0;

        // unsupported length
        m_len   = 13'h0123;
        din_vld = 1'b1;
        cyc();
        chk("lerr_pulse", 32'(len_err), 32'd1);
        chk("lerr_wen", 32'(wen), 32'd0);
        din_vld = 1'b0;
        cyc();
        chk("lerr_clear", 32'(len_err), 32'd0);
        chk("lerr_din_rdy", 32'(din_rdy), 32'd1);
        chk("lerr_busy", 32'(busy), 32'd0);

        // 0x15F0 block, async reset at beat 100
        m_len = 13'h15F0;
        for (int k = 0; k < 100; k++) begin
            din_vld = 1'b1;
            cyc();
            chk("big_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b0, 32'h37AC + k));
        end
        din_vld = 1'b0;
        n_rst   = 1'b0;
        cyc();
        chk_idle("rst_mid");
        n_rst = 1'b1;
        cyc();
        chk("rst_mid_din_rdy", 32'(din_rdy), 32'd1);
        chk("rst_mid_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_mid_wen", 32'(wen), 32'd0);

        // 0x510 block restarts in bank 0; mid-block m_len change ignored
        m_len = 13'h0510;
        for (int k = 0; k < 1296; k++) begin
            if (k == 5) m_len = 13'h01B0;
            din_vld = 1'b1;
            cyc();
            chk("p_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b0, 32'h0588 + k));
        end
        din_vld = 1'b0;
        chk("p_req_rdy", 32'(req_rdy), 32'd1);
        chk("p_id_offset", 32'(id_offset), 32'h0588);
        for (int j = 0; j < 10; j++) begin
            request = 1'b1;
            cyc();
            chk("p_rd", {14'd0, rd_en, rd_bank, rd_addr}, pk(1'b1, 1'b0, 32'h0588 + j));
        end

        // flush mid-read
        flush = 1'b1;
        cyc();
        chk_idle("flush");
        flush   = 1'b0;
        request = 1'b0;
        cyc();
        chk("flush_din_rdy", 32'(din_rdy), 32'd1);
        chk("flush_req_rdy", 32'(req_rdy), 32'd0);

        // 0x3CC block in bank 0, then overlap 0x380 write to bank 1 with bank 0 read
        m_len = 13'h03CC;
        for (int k = 0; k < 972; k++) begin
            din_vld = 1'b1;
            cyc();
            chk("q_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b0, 32'h01B6 + k));
        end
        din_vld = 1'b0;
        chk("q_req_rdy", 32'(req_rdy), 32'd1);
        chk("q_id_offset", 32'(id_offset), 32'h01B6);

        m_len = 13'h0380;
        for (int c = 0; c < 972; c++) begin
            request = 1'b1;
            din_vld = (c >= 76);
            cyc();
            chk("ov_rd", {14'd0, rd_en, rd_bank, rd_addr}, pk(1'b1, 1'b0, 32'h01B6 + c));
            if (c >= 76)
                chk("ov_wr", {14'd0, wen, wr_bank, wr_addr}, pk(1'b1, 1'b1, 32'h0A9E + c - 76));
            else
                chk("ov_wen_idle", 32'(wen), 32'd0);
        end
        request = 1'b0;
        din_vld = 1'b0;
        chk("ov_req_rdy", 32'(req_rdy), 32'd1);
        chk("ov_id_offset", 32'(id_offset), 32'h0A9E);
        chk("ov_din_rdy", 32'(din_rdy), 32'd1);
        chk("ov_busy", 32'(busy), 32'd1);
        cyc();
        chk("ov_tail", 32'({dout_vld, rd_en, wen}), 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
